// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control pipeline.
//   - ALU control codes (4-bit) emitted by the decoder
//   - R-type funct field encodings recognised by the decoder
//   - sequencer state enum
// Optional feature: ALU_CTRL_SHIFT_EN enables the sll/srl funct decode.
package alu_ctrl_pkg;

  localparam logic [3:0] ADD  = 4'b0010;
  localparam logic [3:0] SUB  = 4'b0110;
  localparam logic [3:0] AND  = 4'b0000;
  localparam logic [3:0] OR   = 4'b0001;
  localparam logic [3:0] SLT  = 4'b0111;
  localparam logic [3:0] NOR  = 4'b1100;
  localparam logic [3:0] MULT = 4'b1000;
  localparam logic [3:0] DIV  = 4'b1001;
  localparam logic [3:0] SLL  = 4'b0011;
  localparam logic [3:0] SRL  = 4'b0100;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational aluOp/funct decode to a 4-bit ALU control code.
// Ports:
//   aluOp   in  [1:0] datapath op class (00 add, 10 sub, x1 funct decode)
//   funct   in  [5:0] R-type function field
//   code    out [3:0] ALU control code
//   multi   out       op needs the multicycle unit (mult/div)
//   illegal out       funct not recognised (code falls back to add)
// Optional feature: ALU_CTRL_SHIFT_EN adds sll (000000) and srl (000010).
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [5:0] funct,
  output logic [3:0] code,
  output logic       multi,
  output logic       illegal
);

  always_comb begin
    code    = ADD;
    multi   = 1'b0;
    illegal = 1'b0;
    // aluOp[0] set selects the funct decode regardless of aluOp[1]
    if (aluOp[0]) begin
      case (funct)
        FN_ADD:  code = ADD;
        FN_SUB:  code = SUB;
        FN_AND:  code = AND;
        FN_OR:   code = OR;
        FN_SLT:  code = SLT;
        FN_NOR:  code = NOR;
        FN_MULT: begin
          code  = MULT;
          multi = 1'b1;
        end
        FN_DIV: begin
          code  = DIV;
          multi = 1'b1;
        end
`ifdef ALU_CTRL_SHIFT_EN
        FN_SLL:  code = SLL;
        FN_SRL:  code = SRL;
`endif
        default: illegal = 1'b1;
      endcase
    end else if (aluOp[1]) begin
      code = SUB;
    end
  end

endmodule

// File: rtl/alu_control_pipe.sv
// ALU control decode with a valid/ready handshake and a multicycle hold-off.
// Single-cycle ops produce a result one cycle after accept; mult/div occupy
// the block for MC_LAT cycles (BUSY) before the result is presented.
// Ports:
//   clock      in           rising-edge clock
//   reset_n    in           asynchronous active-low reset
//   in_valid   in           request present
//   in_ready   out          request accepted when in_valid & in_ready
//   aluOp      in  [1:0]    op class
//   funct      in  [5:0]    R-type function field
//   out_valid  out          saida/multi/illegal hold a valid result
//   out_ready  in           consumer takes result when out_valid & out_ready
//   saida      out [OP_W-1:0] ALU control code, zero-extended above bit 3
//   multi      out          result is a multicycle op
//   illegal    out          unrecognised funct
//   busy       out          multicycle countdown in progress
// Parameters: OP_W (>=4) output code width, MC_LAT (>=1) multicycle latency.
// Optional feature: ALU_CTRL_SHIFT_EN enables sll/srl decode (in alu_ctrl_decode).
module alu_control_pipe #(
  parameter int OP_W   = 4,
  parameter int MC_LAT = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluOp,
  input  logic [5:0]      funct,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] saida,
  output logic            multi,
  output logic            illegal,
  output logic            busy
);
  import alu_ctrl_pkg::*;

  localparam int               CNT_W    = $clog2(MC_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 1);
  // With a one-cycle latency multicycle ops go straight to HOLD
  localparam bit               MC_EN    = (MC_LAT > 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic [3:0]       dec_code_p0;
  logic             dec_multi_p0;
  logic             dec_illegal_p0;

  // Stage p0: combinational decode of the request at the input port
  alu_ctrl_decode u_decode (
    .aluOp   (aluOp),
    .funct   (funct),
    .code    (dec_code_p0),
    .multi   (dec_multi_p0),
    .illegal (dec_illegal_p0)
  );

  // HOLD can take a new request in the same cycle its result is consumed
  assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_HOLD);
  assign busy      = (state == ST_BUSY);

  // Stage p1: registered result and sequencing
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      saida   <= '0;
      multi   <= 1'b0;
      illegal <= 1'b0;
    end else if (accept) begin
      saida   <= OP_W'(dec_code_p0);
      multi   <= dec_multi_p0;
      illegal <= dec_illegal_p0;
      if (dec_multi_p0 && MC_EN) begin
        state <= ST_BUSY;
        cnt   <= CNT_LOAD;
      end else begin
        state <= ST_HOLD;
      end
    end else begin
      case (state)
        ST_HOLD: begin
          if (out_ready) state <= ST_IDLE;
        end
        // Counter runs MC_LAT-1 down to 0; the cycle at 0 moves to HOLD,
        // so out_valid rises exactly MC_LAT edges after accept.
        ST_BUSY: begin
          if (cnt == '0) state <= ST_HOLD;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_pipe.sv
// Scoreboard bench for alu_control_pipe: the driver pushes the expected
// result on each accept, a negedge monitor compares every presented result.
module tb_alu_control_pipe;
  localparam int OP_W   = 4;
  localparam int MC_LAT = 4;

  logic            clock    = 1'b0;
  logic            reset_n  = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [1:0]      aluOp    = 2'b00;
  logic [5:0]      funct    = 6'b000000;
  logic            in_ready, out_valid, multi, illegal, busy;
  logic [OP_W-1:0] saida;

  typedef struct packed {
    logic [3:0] code;
    logic       m;
    logic       il;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  alu_control_pipe #(.OP_W(OP_W), .MC_LAT(MC_LAT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluOp     (aluOp),
    .funct     (funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .saida     (saida),
    .multi     (multi),
    .illegal   (illegal),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented result must match the oldest expected entry
  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("result", 32'({saida, multi, illegal}),
            32'({OP_W'(q[0].code), q[0].m, q[0].il}));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Drive one request and wait for accept; returns at accept edge + 1.
  task automatic send(input logic [1:0] op, input logic [5:0] fn,
                      input logic [3:0] code, input logic m, input logic il);
    logic rdy;
    int   guard;
    guard    = 0;
    rdy      = 1'b0;
    in_valid = 1'b1;
    aluOp    = op;
    funct    = fn;
    do begin
      @(negedge clock);
      rdy = in_ready;
      @(posedge clock);
      guard++;
    end while (!rdy && guard < 50);
    if (rdy) q.push_back(exp_t'{code, m, il});
    else     chk("accept_timeout", 32'(in_ready), 32'd1);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle_wait();
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Multicycle op: an unrelated request is held on the input while BUSY
  // and must be ignored; result must appear exactly MC_LAT edges after accept.
  task automatic mc_check(input logic [5:0] fn, input logic [3:0] code);
    int lat;
    send(2'b01, fn, code, 1'b1, 1'b0);
    chk("mc_busy_start", 32'(busy), 32'd1);
    chk("mc_in_ready_start", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    aluOp    = 2'b10;
    funct    = 6'b100000;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
      if (!out_valid) begin
        chk("mc_busy", 32'(busy), 32'd1);
        chk("mc_in_ready", 32'(in_ready), 32'd0);
      end
    end
    in_valid = 1'b0;
    chk("mc_latency", 32'(lat), 32'(MC_LAT));
    chk("mc_busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge
    #1 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_saida", 32'(saida), 32'd0);
    chk("rst_multi", 32'(multi), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // slt with latency 1
    out_ready = 1'b1;
    send(2'b01, 6'b101010, 4'b0111, 1'b0, 1'b0);
    chk("slt_latency1", 32'(out_valid), 32'd1);

    // Decode table, back-to-back
    send(2'b01, 6'b100000, 4'b0010, 1'b0, 1'b0);
    send(2'b11, 6'b100010, 4'b0110, 1'b0, 1'b0);
    send(2'b01, 6'b100100, 4'b0000, 1'b0, 1'b0);
    send(2'b01, 6'b100101, 4'b0001, 1'b0, 1'b0);
    send(2'b11, 6'b100111, 4'b1100, 1'b0, 1'b0);
    send(2'b01, 6'b111111, 4'b0010, 1'b0, 1'b1);
    send(2'b00, 6'b101010, 4'b0010, 1'b0, 1'b0);
    send(2'b10, 6'b101010, 4'b0110, 1'b0, 1'b0);
    send(2'b10, 6'b000000, 4'b0110, 1'b0, 1'b0);
    send(2'b11, 6'b101010, 4'b0111, 1'b0, 1'b0);
`ifdef ALU_CTRL_SHIFT_EN
    send(2'b01, 6'b000010, 4'b0100, 1'b0, 1'b0);
    send(2'b01, 6'b000000, 4'b0011, 1'b0, 1'b0);
`else
    send(2'b01, 6'b000010, 4'b0010, 1'b0, 1'b1);
    send(2'b01, 6'b000000, 4'b0010, 1'b0, 1'b1);
`endif

    // Multicycle ops
    mc_check(6'b011010, 4'b1001);
    idle_wait();
    mc_check(6'b011000, 4'b1000);
    idle_wait();

    // Backpressure: add result held 5 cycles, next request waiting
    out_ready = 1'b0;
    send(2'b00, 6'b000000, 4'b0010, 1'b0, 1'b0);
    in_valid = 1'b1;
    aluOp    = 2'b01;
    funct    = 6'b100100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_saida", 32'(saida), 32'h2);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    send(2'b01, 6'b100100, 4'b0000, 1'b0, 1'b0);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_saida", 32'(saida), 32'h0);
    idle_wait();

    // Reset in BUSY cycle 2: result abandoned
    send(2'b01, 6'b011010, 4'b1001, 1'b1, 1'b0);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_saida", 32'(saida), 32'd0);
    chk("midrst_multi", 32'(multi), 32'd0);
    chk("midrst_illegal", 32'(illegal), 32'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (8) @(posedge clock);
    #1;
    chk("midrst_no_result", 32'(out_valid), 32'd0);
    chk("midrst_no_busy", 32'(busy), 32'd0);

    // Normal operation after reset
    send(2'b10, 6'b111111, 4'b0110, 1'b0, 1'b0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clock);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
